// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder, LSB first, one full_add cell, valid/ready in and out.
// Ports: clk, rst_n (async active-low); in_valid/in_ready with operands a, b, cin;
// out_valid/out_ready with result sum, cout; busy is high while bits are being shifted.
// Optional macro SERIAL_ADD_SUB_EN adds input sub: when set, computes a-b (cout=1 means no borrow).

module full_add (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef SERIAL_ADD_SUB_EN
    ,input logic             sub
`endif
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, next;

    logic [WIDTH-1:0] a_sh, b_sh, b_ld;
    logic [CW-1:0]    cnt;
    logic             carry, c_ld, s, co, last;

`ifdef SERIAL_ADD_SUB_EN
    assign b_ld = sub ? ~b : b;
    assign c_ld = sub | cin;
`else
    assign b_ld = b;
    assign c_ld = cin;
`endif

    full_add u_fa (.a(a_sh[0]), .b(b_sh[0]), .ci(carry), .s(s), .co(co));

    assign last = cnt == CW'(WIDTH - 1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= next;

    always_comb begin
        in_ready  = state == IDLE;
        busy      = state == SHIFT;
        out_valid = state == DONE;
        next      = (state == IDLE  && in_valid)  ? SHIFT :
                    (state == SHIFT && last)      ? DONE  :
                    (state == DONE  && out_ready) ? IDLE  : state;
    end

    // a_sh doubles as the sum shift register: addend bits leave at the LSB
    // while sum bits enter at the MSB, so after WIDTH shifts it holds the sum.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_sh  <= a;
            b_sh  <= b_ld;
            carry <= c_ld;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            a_sh  <= {s, a_sh[WIDTH-1:1]};
            b_sh  <= b_sh >> 1;
            carry <= co;
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum  <= {s, a_sh[WIDTH-1:1]};
                cout <= co;
            end
        end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: scoreboard bench for serial_add_ctrl (WIDTH=8), directed vectors.
module tb_serial_add_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, cin = 1'b0, cout, busy;
    logic [7:0] a = '0, b = '0, sum;
`ifdef SERIAL_ADD_SUB_EN
    logic       sub = 1'b0;
`endif

    int checks = 0, failures = 0, cyc = 0, hs_cyc = 0, prev_hs = 0;
    logic [8:0] sb[$];
    logic prev_ov = 1'b0, ready_due = 1'b0;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
`ifdef SERIAL_ADD_SUB_EN
        , .sub(sub)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    always @(negedge clk) begin
        // inclusive count of rising edges from input handshake to out_valid rise
        if (out_valid && !prev_ov) chk("latency", 64'(cyc - hs_cyc + 1), 9);
        if (ready_due) chk("in_ready_after_out", in_ready, 1);
        ready_due = 1'b0;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual=%0h expected=none", {cout, sum});
            end else chk("result", {cout, sum}, sb.pop_front());
            ready_due = 1'b1;
        end
        prev_ov = out_valid;
    end

    task automatic send(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                        input logic is, input logic [8:0] e, input bit keep);
        bit ok = 0;
        in_valid = 1'b1; a = ia; b = ib; cin = ic;
`ifdef SERIAL_ADD_SUB_EN
        sub = is;
`endif
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL accept_timeout actual=in_ready_low expected=accept a=%0h", ia);
        end else begin
            prev_hs = hs_cyc;
            hs_cyc  = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++; failures++;
            $display("FAIL drain_timeout actual=%0d expected=0 pending", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        @(posedge clk); #1;

        send(8'h3C, 8'h05, 1'b0, 1'b0, 9'h041, 0);
        @(negedge clk);
        chk("busy_in_shift", busy, 1);
        chk("in_ready_in_shift", in_ready, 0);
        drain();
        send(8'hFF, 8'h01, 1'b0, 1'b0, 9'h100, 0); drain();
        send(8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF, 0); drain();

        out_ready = 1'b0;
        send(8'h12, 8'h34, 1'b0, 1'b0, 9'h046, 0);
        for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_sum", sum, 8'h46);
            chk("bp_in_ready", in_ready, 0);
            @(negedge clk);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        drain();

        send(8'h10, 8'h20, 1'b0, 1'b0, 9'h030, 0);
        @(posedge clk); #1 in_valid = 1'b1; a = 8'hAA; b = 8'h01;
        @(posedge clk); #1 in_valid = 1'b0;
        drain();
        repeat (3) begin @(negedge clk); chk("no_phantom_op", out_valid, 0); end
        @(posedge clk); #1;

        send(8'h11, 8'h22, 1'b0, 1'b0, 9'h033, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_sum", sum, 0);
        void'(sb.pop_back());
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", in_ready, 1);
        @(posedge clk); #1;
        send(8'h80, 8'h80, 1'b1, 1'b0, 9'h101, 0); drain();

        send(8'h01, 8'h02, 1'b1, 1'b0, 9'h004, 1);
        send(8'hA5, 8'h5A, 1'b0, 1'b0, 9'h0FF, 1);
        chk("b2b_interval1", 64'(hs_cyc - prev_hs), 10);
        send(8'hC8, 8'h64, 1'b1, 1'b0, 9'h12D, 0);
        chk("b2b_interval2", 64'(hs_cyc - prev_hs), 10);
        drain();

`ifdef SERIAL_ADD_SUB_EN
        send(8'h05, 8'h07, 1'b0, 1'b1, 9'h0FE, 0); drain();
        send(8'h07, 8'h05, 1'b0, 1'b1, 9'h102, 0); drain();
        send(8'h07, 8'h05, 1'b1, 1'b0, 9'h00D, 0); drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
